// File: rtl/mem_dma_arb.sv
// Arbitrates a single memory port between CPU pass-through accesses and a
// 256-byte page-to-OAM DMA engine triggered by a CPU write to DMA_REG_ADDR.
module mem_dma_arb #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy,
  output logic        cycle_odd
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;

  state_t     state, state_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] data_q, data_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      page      <= 8'h00;
      count     <= 8'h00;
      data_q    <= 8'h00;
      cycle_odd <= 1'b0;
    end else begin
      state     <= state_nxt;
      page      <= page_nxt;
      count     <= count_nxt;
      data_q    <= data_nxt;
      cycle_odd <= ~cycle_odd;
    end
  end

  // Everything is forced quiet while reset is held so an aborted DMA never
  // leaks a request during the reset cycle itself.
  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    count_nxt = count;
    data_nxt  = data_q;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    cpu_rdata = 8'h00;
    cpu_rdy   = 1'b0;
    dma_busy  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_wen) begin
            if (cpu_addr == DMA_REG_ADDR) begin
              cpu_rdy   = 1'b1;
              page_nxt  = cpu_wdata;
              count_nxt = 8'h00;
              state_nxt = HALT;
            end else begin
              mem_wen   = 1'b1;
              mem_addr  = cpu_addr;
              mem_wdata = cpu_wdata;
              cpu_rdy   = mem_rdy;
            end
          end else if (cpu_ren) begin
            mem_ren  = 1'b1;
            mem_addr = cpu_addr;
            cpu_rdy  = mem_rdy;
            if (mem_rdy) cpu_rdata = mem_rdata;
          end
        end
        HALT: begin
          dma_busy  = 1'b1;
          state_nxt = cycle_odd ? ALIGN : RD;
        end
        ALIGN: begin
          dma_busy  = 1'b1;
          state_nxt = RD;
        end
        RD: begin
          dma_busy = 1'b1;
          mem_ren  = 1'b1;
          mem_addr = {page, count};
          if (mem_rdy) begin
            data_nxt  = mem_rdata;
            state_nxt = WR;
          end
        end
        WR: begin
          dma_busy  = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = OAM_DATA_ADDR;
          mem_wdata = data_q;
          // The 8-bit counter stops at 255 so the page never wraps into the next one.
          if (mem_rdy) begin
            if (count == 8'hFF) begin
              state_nxt = IDLE;
            end else begin
              count_nxt = count + 8'd1;
              state_nxt = RD;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_arb.sv
// Bench for mem_dma_arb: a step-counting DMA model checks every output each
// cycle, with directed scenarios pinning durations, ordering and reset abort.
module tb_mem_dma_arb;

  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM     = 16'h2004;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wen, cpu_ren;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rdy;
  logic        mem_wen, mem_ren;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rdy;
  logic        dma_busy, cycle_odd;

  always #5 clk = ~clk;

  mem_dma_arb #(.DMA_REG_ADDR(DMA_REG), .OAM_DATA_ADDR(OAM)) dut (
    .clk(clk), .rst(rst),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .dma_busy(dma_busy), .cycle_odd(cycle_odd)
  );

  // Unwritten memory reads back the low address byte, so page P holds 0..255.
  bit         written [0:65535];
  bit   [7:0] wmem    [0:65535];
  assign mem_rdata = written[mem_addr] ? wmem[mem_addr] : mem_addr[7:0];

  int n_total = 0;
  int n_pass  = 0;

  // Model: DMA progress is a step number, -2 halt, -1 align, 0..511 read/write pairs.
  bit         m_known = 0, m_busy = 0, m_par = 0;
  int         m_phase = 0;
  logic [7:0] m_page = 8'h00, m_data = 8'h00;

  int          busy_total = 0, rdy_in_busy = 0;
  logic [7:0]  oam_q[$];
  logic [15:0] last_rd_addr = 16'h0000;
  bit          last_rdy = 0;
  bit          pw_en = 0;
  logic [15:0] pw_addr;
  logic [7:0]  pw_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkCycle();
    logic        e_wen, e_ren, e_rdy, e_busy;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata, e_rdata;
    bit          old_par;
    e_wen = 0; e_ren = 0; e_rdy = 0; e_busy = 0;
    e_addr = 16'h0000; e_wdata = 8'h00; e_rdata = 8'h00;
    if (!rst && !m_busy) begin
      if (cpu_wen && cpu_addr == DMA_REG) e_rdy = 1;
      else if (cpu_wen) begin
        e_wen = 1; e_addr = cpu_addr; e_wdata = cpu_wdata; e_rdy = mem_rdy;
      end else if (cpu_ren) begin
        e_ren = 1; e_addr = cpu_addr; e_rdy = mem_rdy;
        e_rdata = mem_rdy ? mem_rdata : 8'h00;
      end
    end else if (!rst) begin
      e_busy = 1;
      if (m_phase >= 0 && m_phase % 2 == 0) begin
        e_ren = 1; e_addr = {m_page, 8'(m_phase / 2)};
      end else if (m_phase >= 0) begin
        e_wen = 1; e_addr = OAM; e_wdata = m_data;
      end
    end
    checkOutput("mem_wen", mem_wen, e_wen);
    checkOutput("mem_ren", mem_ren, e_ren);
    checkOutput("mem_addr", mem_addr, e_addr);
    checkOutput("mem_wdata", mem_wdata, e_wdata);
    checkOutput("cpu_rdy", cpu_rdy, e_rdy);
    checkOutput("cpu_rdata", cpu_rdata, e_rdata);
    checkOutput("dma_busy", dma_busy, e_busy);
    if (m_known) checkOutput("cycle_odd", cycle_odd, m_par);

    last_rdy = cpu_rdy;
    if (dma_busy) busy_total++;
    if (dma_busy && cpu_rdy) rdy_in_busy++;
    if (mem_ren) last_rd_addr = mem_addr;
    if (!rst && mem_wen && mem_rdy) begin
      pw_en = 1; pw_addr = mem_addr; pw_data = mem_wdata;
      if (mem_addr == OAM) oam_q.push_back(mem_wdata);
    end

    old_par = m_par;
    if (rst) begin
      m_known = 1; m_par = 0; m_busy = 0; m_phase = 0;
    end else begin
      m_par = !m_par;
      if (!m_busy) begin
        if (cpu_wen && cpu_addr == DMA_REG) begin
          m_busy = 1; m_page = cpu_wdata; m_phase = -2;
        end
      end else if (m_phase == -2) m_phase = old_par ? -1 : 0;
      else if (m_phase == -1) m_phase = 0;
      else if (mem_rdy) begin
        if (m_phase % 2 == 0) m_data = mem_rdata;
        if (m_phase == 511) m_busy = 0;
        else m_phase++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    #1;
    if (pw_en) begin
      written[pw_addr] = 1;
      wmem[pw_addr] = pw_data;
      pw_en = 0;
    end
  endtask

  task automatic runDma(input logic [7:0] page, input bit odd_halt, input int stall_at,
                        input int abort_after, input bit hold_read,
                        output int busy_cycles, output int st);
    int  b0, reads, stall_left, budget;
    bit  done;
    logic want;
    cpu_wen = 0; cpu_ren = 0; mem_rdy = 1;
    want = odd_halt ? 1'b0 : 1'b1;
    for (int k = 0; k < 4 && cycle_odd !== want; k++) tick();
    b0 = busy_total; st = oam_q.size(); reads = 0; stall_left = 3; done = 0; budget = 0;
    cpu_wen = 1; cpu_addr = DMA_REG; cpu_wdata = page;
    tick();
    cpu_wen = 0;
    if (hold_read) begin
      cpu_ren = 1; cpu_addr = 16'h0000;
    end
    while (!done && budget < 1200) begin
      if (abort_after >= 0 && int'(oam_q.size()) - st == abort_after) done = 1;
      else begin
        mem_rdy = 1;
        if (mem_ren && reads == stall_at && stall_left > 0) begin
          mem_rdy = 0; stall_left--;
        end else if (mem_ren) reads++;
        tick();
        budget++;
        if (!dma_busy) done = 1;
      end
    end
    mem_rdy = 1;
    checkOutput("dma_completed_in_budget", done, 1);
    busy_cycles = busy_total - b0;
  endtask

  task automatic checkSeq(input int st);
    int err = 0;
    checkOutput("dma_write_count", int'(oam_q.size()) - st, 256);
    for (int i = 0; i < 256; i++)
      if (st + i >= oam_q.size() || oam_q[st + i] !== 8'(i)) err++;
    checkOutput("dma_write_order_errors", err, 0);
  endtask

  task automatic applyStimulus();
    rst = ($urandom_range(0, 999) == 0);
    mem_rdy = ($urandom_range(0, 3) != 0);
    if (!(cpu_wen || cpu_ren) || last_rdy) begin
      int sel = $urandom_range(0, 99);
      cpu_wen = (sel < 35) || (sel >= 60 && sel < 65);
      cpu_ren = (sel >= 30 && sel < 65);
      cpu_addr = ($urandom_range(0, 19) == 0) ? DMA_REG : 16'($urandom);
      cpu_wdata = 8'($urandom);
    end
  endtask

  initial begin
    int busy, st, r0;
    rst = 1; cpu_wen = 0; cpu_ren = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdy = 0;
    tick();
    tick();
    rst = 0;
    #1;
    checkOutput("reset_cycle_odd", cycle_odd, 0);
    checkOutput("reset_dma_busy", dma_busy, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);

    mem_rdy = 1; cpu_wen = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
    #1;
    checkOutput("pt_write_wen", mem_wen, 1);
    checkOutput("pt_write_addr", mem_addr, 16'h0200);
    checkOutput("pt_write_data", mem_wdata, 8'h5A);
    checkOutput("pt_write_rdy", cpu_rdy, 1);
    tick();
    cpu_wen = 0; cpu_ren = 1;
    #1;
    checkOutput("pt_read_data", cpu_rdata, 8'h5A);
    checkOutput("pt_read_rdy", cpu_rdy, 1);
    tick();
    cpu_ren = 0;

    runDma(8'h03, 0, -1, -1, 0, busy, st);
    checkOutput("dma_even_duration", busy, 513);
    checkSeq(st);
    checkOutput("dma_first_byte", oam_q[st], 8'h00);
    checkOutput("dma_last_byte", oam_q[st + 255], 8'hFF);

    runDma(8'h03, 1, -1, -1, 0, busy, st);
    checkOutput("dma_odd_duration", busy, 514);
    checkSeq(st);

    runDma(8'h03, 0, 9, -1, 0, busy, st);
    checkOutput("dma_stall_duration", busy, 516);
    checkSeq(st);

    r0 = rdy_in_busy;
    runDma(8'hFF, 0, -1, -1, 1, busy, st);
    checkOutput("page_ff_duration", busy, 513);
    checkOutput("page_ff_last_read", last_rd_addr, 16'hFFFF);
    checkOutput("page_ff_cpu_rdy_during_dma", rdy_in_busy - r0, 0);
    checkSeq(st);
    checkOutput("pending_read_rdy", cpu_rdy, 1);
    checkOutput("pending_read_addr", mem_addr, 16'h0000);
    checkOutput("pending_read_data", cpu_rdata, 8'h00);
    tick();
    cpu_ren = 0;

    runDma(8'h03, 0, -1, 100, 0, busy, st);
    checkOutput("abort_writes_before_reset", int'(oam_q.size()) - st, 100);
    rst = 1;
    #1;
    checkOutput("abort_mem_ren", mem_ren, 0);
    checkOutput("abort_mem_addr", mem_addr, 0);
    checkOutput("abort_dma_busy", dma_busy, 0);
    tick();
    rst = 0;
    #1;
    checkOutput("after_abort_dma_busy", dma_busy, 0);
    checkOutput("after_abort_mem_ren", mem_ren, 0);
    repeat (20) tick();
    checkOutput("abort_no_more_writes", int'(oam_q.size()) - st, 100);
    cpu_wen = 1; cpu_addr = 16'h0123; cpu_wdata = 8'h77;
    #1;
    checkOutput("after_abort_pt_wen", mem_wen, 1);
    checkOutput("after_abort_pt_addr", mem_addr, 16'h0123);
    tick();
    cpu_wen = 0;

    for (int c = 0; c < 4000; c++) begin
      applyStimulus();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_dma_arb.md
MEM_DMA_ARB -- requirements
Module: mem_dma_arb

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, 16'h2004, destination address of every DMA write.
REQ-003 SHALL have ports clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports cpu_wen  in  1  CPU write request; cpu_ren  in  1  CPU read request.
REQ-005 SHALL have ports cpu_addr  in  t_addr (16)  CPU address; cpu_wdata  in  t_data (8)  CPU write data.
REQ-006 SHALL have ports cpu_rdata  out  t_data  CPU read data; cpu_rdy  out  1  CPU transaction complete.
REQ-007 SHALL have ports mem_wen  out  1; mem_ren  out  1; mem_addr  out  t_addr; mem_wdata  out  t_data (to mem_top wen/ren/addr_in/data_in).
REQ-008 SHALL have ports mem_rdy  in  1; mem_rdata  in  t_data (from mem_top rdy/data_out).
REQ-009 SHALL have ports dma_busy  out  1  DMA in progress; cycle_odd  out  1  cycle parity.

Function
REQ-010 Handshake: requester holds request, addr, wdata stable; transaction completes on the first rising clk edge where the ready input is 1; read data valid in that same cycle.
REQ-011 cycle_odd SHALL toggle every clk after reset, 0 in first cycle after reset.
REQ-012 States: IDLE, HALT, ALIGN, RD, WR.
REQ-013 IDLE, cpu_wen=1, cpu_addr!=DMA_REG_ADDR: mem_wen=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_rdy=mem_rdy (combinational pass-through).
REQ-014 IDLE, cpu_ren=1, cpu_wen=0: mem_ren=1, mem_addr=cpu_addr, cpu_rdata=mem_rdata, cpu_rdy=mem_rdy.
REQ-015 cpu_wen and cpu_ren both 1: write wins; read not forwarded.
REQ-016 IDLE, cpu_wen=1, cpu_addr==DMA_REG_ADDR: not forwarded (mem_wen=0); cpu_rdy=1 that cycle; page register <= cpu_wdata; byte counter <= 0; next state HALT.
REQ-017 HALT: one cycle, no memory request; next ALIGN if cycle_odd=1 in HALT, else RD.
REQ-018 ALIGN: one cycle, no memory request; next RD.
REQ-019 RD: mem_ren=1, mem_addr={page, counter}; on mem_rdy=1 latch mem_rdata into data register, next WR.
REQ-020 WR: mem_wen=1, mem_addr=OAM_DATA_ADDR, mem_wdata=data register; on mem_rdy=1: counter==255 -> IDLE, else counter+1, next RD.
REQ-021 Counter SHALL be 8 bits; page 8'hFF reads 16'hFF00..16'hFFFF, never touches 16'h0000.
REQ-022 dma_busy=1 in HALT, ALIGN, RD, WR; 0 in IDLE.
REQ-023 While dma_busy=1: cpu_rdy=0, CPU requests ignored and not forwarded; CPU must hold its request; served in IDLE after DMA ends.
REQ-024 mem_wen and mem_ren SHALL never be 1 simultaneously.
REQ-025 With mem_rdy held 1, DMA duration (trigger cycle excluded) SHALL be 513 cycles (even HALT) or 514 (odd HALT); each mem_rdy=0 cycle adds one.
REQ-026 cpu_rdata SHALL be 0 outside a completing IDLE read.

Reset
REQ-027 rst=1 at a clk edge: state IDLE, counter 0, page 0, data register 0, cycle_odd 0.
REQ-028 During/after reset all outputs 0: mem_wen, mem_ren, mem_addr, mem_wdata, cpu_rdata, cpu_rdy, dma_busy.
REQ-029 Reset mid-DMA SHALL abort immediately; no further memory request; next cpu_wen served as IDLE pass-through.

Verification
REQ-030 Pass-through: mem_rdy=1, CPU write 0x0200<=0x5A then read 0x0200 -> mem_wen/addr 0x0200/data 0x5A, then cpu_rdata=0x5A, cpu_rdy=1 each cycle.
REQ-031 DMA: memory 0x0300+i = i, CPU writes 0x03 to 0x4014 on even parity, mem_rdy=1 -> 256 writes to 0x2004 data 0x00..0xFF in order, dma_busy high 513 cycles.
REQ-032 Parity: same trigger with HALT odd -> one ALIGN cycle, dma_busy high 514 cycles.
REQ-033 Stall: mem_rdy low 3 cycles on 10th read -> mem_addr/mem_ren held, sequence intact, duration +3.
REQ-034 Page 0xFF, CPU read of 0x0000 pending during DMA -> last read 0xFFFF, cpu_rdy=0 throughout DMA, CPU read completes after dma_busy falls.
REQ-035 rst asserted at counter 100 -> next cycle all outputs 0, dma_busy=0, no further 0x2004 writes.
